// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: REDUX-V opcodes, control-bit indices, FSM states, decode classes
package multicycle_control_unit_pkg;
  localparam int OP_W = 4;
  localparam int ULA_W = 3;
  localparam logic [3:0] OPC_BRZR = 4'd0;
  localparam logic [3:0] OPC_JI = 4'd1;
  localparam logic [3:0] OPC_LD = 4'd2;
  localparam logic [3:0] OPC_ST = 4'd3;
  localparam logic [3:0] OPC_ADDI = 4'd4;
  localparam logic [3:0] OPC_PUSH = 4'd5;
  localparam logic [3:0] OPC_POP = 4'd6;
  localparam logic [3:0] OPC_MOV = 4'd7;
  localparam logic [3:0] OPC_NOT = 4'd8;
  localparam logic [3:0] OPC_ADD = 4'd12;
  localparam int BR = 0;
  localparam int J = 1;
  localparam int RA = 2;
  localparam int RE = 3;
  localparam int DM = 4;
  localparam int WE = 5;
  localparam int SE = 6;
  localparam int SP = 7;
  localparam int SPR = 8;
  typedef logic [0:9] sig_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_e;
  typedef enum logic [2:0] {C_BRANCH, C_JUMP, C_MEM_RD, C_MEM_WR, C_ALU} cls_e;
  function automatic int unsigned alu_sel(logic [3:0] o, int w);
    return 32'(o) & ~(32'd1 << w);
  endfunction
endpackage

// File: rtl/multicycle_control_unit_op_decoder.sv
// multicycle_control_unit_op_decoder: latched opcode ir -> raw control set, ula, class, illegal
module multicycle_control_unit_op_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter int OP = OP_W,
  parameter int ULA_OP = ULA_W
) (
  input  logic [OP-1:0]     ir,
  output logic [0:9]        set,
  output logic [ULA_OP-1:0] ula,
  output cls_e              cls,
  output logic              illegal
);
  logic [3:0] o;
  always_comb begin
    o = ir[3:0];
    illegal = 32'(ir) > 32'd15;
    set = '0;
    ula = '0;
    cls = C_ALU;
    case (o)
      OPC_BRZR: begin set[BR] = 1'b1; cls = C_BRANCH; end
      OPC_JI: begin set[J] = 1'b1; cls = C_JUMP; end
      OPC_LD: begin set[RA] = 1'b1; set[RE] = 1'b1; set[DM] = 1'b1; cls = C_MEM_RD; end
      OPC_ST: begin set[WE] = 1'b1; cls = C_MEM_WR; end
      OPC_ADDI: begin
        set[RA] = 1'b1; set[SE] = 1'b1; set[RE] = 1'b1;
        ula = ULA_OP'(alu_sel(OPC_ADD, ULA_OP));
      end
      OPC_PUSH: begin
        set[RA] = 1'b1; set[RE] = 1'b1; set[WE] = 1'b1; set[DM] = 1'b1; set[SP] = 1'b1;
        cls = C_MEM_WR;
      end
      OPC_POP: begin
        set[RE] = 1'b1; set[DM] = 1'b1; set[SP] = 1'b1; set[SPR] = 1'b1;
        cls = C_MEM_RD;
      end
      OPC_MOV: set[RE] = 1'b1;
      default: begin
        set[RE] = 1'b1;
        ula = (o >= OPC_NOT) ? ULA_OP'(alu_sel(o, ULA_OP)) : '0;
      end
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: REDUX-V FETCH/DECODE/EXECUTE/MEM/WB sequencer; run/op/zero/mem_ready in, stage-qualified controls, instr_done, sticky fault out
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OP = OP_W,
  parameter int ULA_OP = ULA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [OP-1:0]     op,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              ir_we,
  output logic              pc_we,
  output logic [0:9]        signals,
  output logic [ULA_OP-1:0] ula_op,
  output logic              instr_done,
  output logic              fault
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_e state_q, state_d, done_to;
  logic [OP-1:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:9] set;
  logic [ULA_OP-1:0] ula;
  cls_e cls;
  logic illegal, in_mem, timeout, active, short_op;
  multicycle_control_unit_op_decoder #(.OP(OP), .ULA_OP(ULA_OP)) u_dec (
    .ir(ir_q), .set(set), .ula(ula), .cls(cls), .illegal(illegal)
  );
  always_comb begin
    in_mem = state_q == S_FETCH || state_q == S_MEM;
    timeout = in_mem && !mem_ready && cnt_q == CW'(MAX_WAIT);
    short_op = cls == C_BRANCH || cls == C_JUMP;
    done_to = run ? S_FETCH : S_IDLE;
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: state_d = timeout ? S_FAULT : mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = illegal ? S_FAULT : S_EXEC;
      S_EXEC: state_d = short_op ? done_to : (cls == C_ALU) ? S_WB : S_MEM;
      S_MEM: state_d = timeout ? S_FAULT : !mem_ready ? S_MEM : set[RE] ? S_WB : done_to;
      S_WB: state_d = done_to;
      default: state_d = S_FAULT;
    endcase
    // counter only survives while waiting in the same memory state, so any entry reloads it to 0
    cnt_d = (in_mem && !mem_ready && state_d == state_q) ? cnt_q + 1'b1 : '0;
    ir_d = (state_q == S_FETCH && mem_ready) ? op : ir_q;
    active = !illegal && (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});
    mem_req = in_mem;
    ir_we = state_q == S_FETCH && mem_ready;
    pc_we = ir_we || (state_q == S_EXEC && (cls == C_JUMP || (cls == C_BRANCH && zero)));
    signals = '0;
    signals[RA] = active && set[RA];
    signals[SE] = active && set[SE];
    signals[SP] = active && set[SP];
    signals[SPR] = active && set[SPR];
    signals[BR] = state_q == S_EXEC && set[BR] && zero;
    signals[J] = state_q == S_EXEC && set[J];
    signals[DM] = state_q == S_MEM && set[DM];
    signals[WE] = state_q == S_MEM && set[WE];
    signals[RE] = state_q == S_WB && set[RE];
    ula_op = (state_q inside {S_EXEC, S_MEM, S_WB}) ? ula : '0;
    // stores finish in MEM; everything that writes a register finishes in WB
    instr_done = (state_q == S_EXEC && short_op) || (state_q == S_MEM && mem_ready && !set[RE])
                 || state_q == S_WB;
    fault = state_q == S_FAULT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
